// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
//   Responder for the core's data-memory port. Every cycle is a read; load data
//   appears one cycle after the address is sampled. Address bit 29 selects the
//   region: 0 = synchronous RAM (word index i_addr[RAM_AW-1:0], upper bits
//   alias), 1 = MMIO page (register i_addr[1:0]):
//     0 CYCLE    RO  free-running 32-bit cycle counter
//     1 CON_DATA WO  push i_wdata[7:0] into the console FIFO (needs i_mask[0])
//     2 CON_STAT RW  {16'b0, count[7:0], 5'b0, overflow, full, empty};
//                    writing bit 2 (with i_mask[0]) clears overflow
//     3 reserved     reads 0
//   The console FIFO drains to an external sink via o_con_valid/i_con_ready.
//
//   Build option: define DMEM_CONSOLE_EN to build the console FIFO. Without it
//   the console outputs are tied to 0 and CON_DATA/CON_STAT are inert.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   i_addr[29:0]        word address
//   i_wdata[31:0]       lane-aligned store data
//   i_we, i_mask[3:0]   write enable and byte enables
//   o_rdata[31:0]       load data for the address sampled on the previous edge
//   o_con_valid/data    console FIFO head byte and its valid flag
//   i_con_ready         sink accepts the head byte
// -----------------------------------------------------------------------------
module data_mem_resp #(
   parameter int RAM_AW  = 10,
   parameter int FIFO_AW = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic        i_we,
   input  logic [3:0]  i_mask,
   output logic [31:0] o_rdata,
   output logic        o_con_valid,
   output logic [7:0]  o_con_data,
   input  logic        i_con_ready
);

   typedef enum logic [1:0] {
      REG_CYCLE    = 2'd0,
      REG_CON_DATA = 2'd1,
      REG_CON_STAT = 2'd2,
      REG_RSVD     = 2'd3
   } mmio_reg_e;

   logic              is_mmio;
   mmio_reg_e         mmio_sel;
   logic [RAM_AW-1:0] ram_idx;

   assign is_mmio  = i_addr[29];
   assign mmio_sel = mmio_reg_e'(i_addr[1:0]);
   assign ram_idx  = i_addr[RAM_AW-1:0];

   // Most address bits are deliberately ignored (aliasing inside each region).
   logic unused_addr;
   assign unused_addr = ^i_addr;

   // ---------------------------------------------------------------- RAM ----
   logic [31:0] ram [0:(1<<RAM_AW)-1];
   logic [31:0] ram_q;

   // NOTE: the RAM array and its read register have no reset so the array maps
   // onto block RAM; o_rdata is forced to 0 during reset through the select.
   always_ff @(posedge clk) begin
      ram_q <= ram[ram_idx];  // old word on read-during-write (read-first)
      if (i_we && !is_mmio) begin
         for (int k = 0; k < 4; k++) begin
            if (i_mask[k]) ram[ram_idx][8*k +: 8] <= i_wdata[8*k +: 8];
         end
      end
   end

   // ----------------------------------------------------------- console ----
   logic [31:0] con_stat;

`ifdef DMEM_CONSOLE_EN
   localparam int DEPTH = 1 << FIFO_AW;

   logic [7:0]         fifo_mem [0:DEPTH-1];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               overflow;
   logic               fifo_empty, fifo_full;
   logic               push_req, push_ok, pop, ovf_clr;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == (FIFO_AW+1)'(DEPTH));
   assign pop        = !fifo_empty && i_con_ready;
   assign push_req   = i_we && is_mmio && (mmio_sel == REG_CON_DATA) && i_mask[0];
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign push_ok    = push_req && (!fifo_full || pop);
   assign ovf_clr    = i_we && is_mmio && (mmio_sel == REG_CON_STAT) &&
                       i_mask[0] && i_wdata[2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (FIFO_AW+1)'(1);
            2'b01:   count <= count - (FIFO_AW+1)'(1);
            default: count <= count;
         endcase
         // Set wins over a simultaneous clear.
         if (push_req && !push_ok) overflow <= 1'b1;
         else if (ovf_clr)         overflow <= 1'b0;
      end
   end

   // When full, wr_ptr == rd_ptr: a push+pop overwrites the slot whose byte
   // the sink consumes on that same edge.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= i_wdata[7:0];
   end

   assign con_stat    = {16'h0000, 8'(count), 5'b00000, overflow, fifo_full, fifo_empty};
   assign o_con_valid = !fifo_empty;
   assign o_con_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
`else
   assign con_stat    = 32'h0000_0000;
   assign o_con_valid = 1'b0;
   assign o_con_data  = 8'h00;

   logic unused_console;
   assign unused_console = i_con_ready ^ FIFO_AW[0];
`endif

   // ------------------------------------------------------- MMIO / read ----
   logic [31:0] cycle_cnt;
   logic [31:0] mmio_rd;
   logic [31:0] mmio_q;
   logic        rd_mmio_q;

   // NOTE: every variable assigned in always_comb gets a default first so no
   // path can leave it holding a value (which would infer a latch).
   always_comb begin
      mmio_rd = 32'h0000_0000;
      case (mmio_sel)
         REG_CYCLE:    mmio_rd = cycle_cnt;
         REG_CON_STAT: mmio_rd = con_stat;
         default:      mmio_rd = 32'h0000_0000;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values (CYCLE and STAT reads see the old state).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= 32'h0000_0000;
         mmio_q    <= 32'h0000_0000;
         rd_mmio_q <= 1'b1;  // selects the zeroed MMIO register while in reset
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         mmio_q    <= mmio_rd;
         rd_mmio_q <= is_mmio;
      end
   end

   assign o_rdata = rd_mmio_q ? mmio_q : ram_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_data_mem_resp
//   Self-checking bench for data_mem_resp (FIFO_AW=2). A behavioural model
//   (associative-array RAM, byte queue FIFO, integer cycle count) predicts
//   every output; a vector table and hand-written sequences add explicit
//   expected values. Console expectations follow DMEM_CONSOLE_EN.
// -----------------------------------------------------------------------------
module tb_data_mem_resp;

   localparam int TB_RAM_AW  = 10;
   localparam int TB_FIFO_AW = 2;
   localparam int TB_DEPTH   = 1 << TB_FIFO_AW;
`ifdef DMEM_CONSOLE_EN
   localparam bit CON_EN = 1'b1;
`else
   localparam bit CON_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [29:0] i_addr = '0;
   logic [31:0] i_wdata = '0;
   logic        i_we = 1'b0;
   logic [3:0]  i_mask = '0;
   logic [31:0] o_rdata;
   logic        o_con_valid;
   logic [7:0]  o_con_data;
   logic        i_con_ready = 1'b0;

   data_mem_resp #(.RAM_AW(TB_RAM_AW), .FIFO_AW(TB_FIFO_AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_addr      (i_addr),
      .i_wdata     (i_wdata),
      .i_we        (i_we),
      .i_mask      (i_mask),
      .o_rdata     (o_rdata),
      .o_con_valid (o_con_valid),
      .o_con_data  (o_con_data),
      .i_con_ready (i_con_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ------------------------------------------------------------ model ----
   bit [31:0] ram_m [int];
   bit [7:0]  fifo_q [$];
   bit        ovf_m = 1'b0;
   bit [31:0] cyc_m = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit [31:0] stat_m();
      bit [31:0] s;
      s = 32'h0;
      if (CON_EN) begin
         s[0]    = (fifo_q.size() == 0);
         s[1]    = (fifo_q.size() == TB_DEPTH);
         s[2]    = ovf_m;
         s[15:8] = 8'(fifo_q.size());
      end
      return s;
   endfunction

   task automatic model_reset();
      fifo_q.delete();
      ovf_m = 1'b0;
      cyc_m = 32'h0;
   endtask

   // One bus cycle: predict, drive, clock, compare. Called at posedge+1.
   task automatic step(input logic [29:0] addr, input logic [31:0] wdata,
                       input logic we, input logic [3:0] mask, input logic ready);
      bit [31:0] exp_rd;
      bit        chk_rd;
      int        idx;
      bit        pop, push_req, clr, accept;
      bit [31:0] w;

      chk_rd = 1'b1;
      exp_rd = 32'h0;
      idx    = int'(addr[TB_RAM_AW-1:0]);
      if (!addr[29]) begin
         if (ram_m.exists(idx)) exp_rd = ram_m[idx];
         else chk_rd = 1'b0;
      end else begin
         case (addr[1:0])
            2'd0:    exp_rd = cyc_m;
            2'd2:    exp_rd = stat_m();
            default: exp_rd = 32'h0;
         endcase
      end

      cyc_m = cyc_m + 32'd1;
      if (we && !addr[29]) begin
         if (ram_m.exists(idx) || mask == 4'hF) begin
            w = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
            for (int k = 0; k < 4; k++) if (mask[k]) w[8*k +: 8] = wdata[8*k +: 8];
            ram_m[idx] = w;
         end
      end
      if (CON_EN) begin
         pop      = (fifo_q.size() > 0) && ready;
         push_req = we && addr[29] && (addr[1:0] == 2'd1) && mask[0];
         clr      = we && addr[29] && (addr[1:0] == 2'd2) && mask[0] && wdata[2];
         accept   = push_req && ((fifo_q.size() < TB_DEPTH) || pop);
         if (pop) void'(fifo_q.pop_front());
         if (accept) fifo_q.push_back(wdata[7:0]);
         if (push_req && !accept) ovf_m = 1'b1;
         else if (clr) ovf_m = 1'b0;
      end

      i_addr = addr; i_wdata = wdata; i_we = we; i_mask = mask; i_con_ready = ready;
      @(posedge clk);
      #1;
      if (chk_rd) check("rdata", o_rdata, exp_rd);
      check("con_valid", 32'(o_con_valid), 32'(fifo_q.size() > 0));
      check("con_data", 32'(o_con_data), 32'((fifo_q.size() > 0) ? fifo_q[0] : 8'h00));
   endtask

   // ---------------------------------------------------------- vectors ----
   typedef struct {
      logic [29:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [3:0]  mask;
      logic        chk;
      logic [31:0] exp;
   } vec_t;

   localparam logic [29:0] A_CYCLE = 30'h2000_0000;
   localparam logic [29:0] A_DATA  = 30'h2000_0001;
   localparam logic [29:0] A_STAT  = 30'h2000_0002;

   vec_t vecs [7];
   bit [7:0] seen [$];

   initial begin
      vecs[0] = '{30'h10, 32'hDEAD_BEEF, 1'b1, 4'hF, 1'b0, 32'h0};
      vecs[1] = '{30'h10, 32'h0000_00AA, 1'b1, 4'h1, 1'b0, 32'h0};
      vecs[2] = '{30'h10, 32'h5500_0000, 1'b1, 4'h8, 1'b0, 32'h0};
      vecs[3] = '{30'h10, 32'h0,         1'b0, 4'h0, 1'b1, 32'h55AD_BEAA};
      vecs[4] = '{30'h05, 32'h2222_2222, 1'b1, 4'hF, 1'b0, 32'h0};
      vecs[5] = '{30'h05, 32'h1111_1111, 1'b1, 4'hF, 1'b1, 32'h2222_2222};
      vecs[6] = '{30'h05, 32'h0,         1'b0, 4'h0, 1'b1, 32'h1111_1111};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset_rdata", o_rdata, 32'h0);
      check("reset_valid", 32'(o_con_valid), 32'h0);
      check("reset_data", 32'(o_con_data), 32'h0);
      rst = 1'b0;
      model_reset();

      // Cycle counter straight after release: 0, 1, 2, ...
      for (int i = 0; i < 5; i++) begin
         step(A_CYCLE, 32'h0, 1'b0, 4'h0, 1'b0);
         check("cycle_seq", o_rdata, 32'(i));
      end

      // Counter wrap.
      force dut.cycle_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.cycle_cnt;
      cyc_m = 32'hFFFF_FFFE;
      step(A_CYCLE, 32'h0, 1'b1, 4'hF, 1'b0);  // write to CYCLE is ignored
      check("cycle_fe", o_rdata, 32'hFFFF_FFFE);
      step(A_CYCLE, 32'h0, 1'b0, 4'h0, 1'b0);
      check("cycle_ff", o_rdata, 32'hFFFF_FFFF);
      step(A_CYCLE, 32'h0, 1'b0, 4'h0, 1'b0);
      check("cycle_wrap", o_rdata, 32'h0);

      // Byte masks and read-first table.
      for (int i = 0; i < 7; i++) begin
         step(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].mask, 1'b0);
         if (vecs[i].chk) check($sformatf("vec%0d", i), o_rdata, vecs[i].exp);
      end

      // FIFO overflow.
      for (int b = 1; b <= 5; b++) step(A_DATA, 32'(b), 1'b1, 4'h1, 1'b0);
      step(A_STAT, 32'h0, 1'b0, 4'h0, 1'b0);
      check("stat_ovf", o_rdata, CON_EN ? 32'h0000_0406 : 32'h0);
      for (int b = 1; b <= 4; b++) begin
         check("drain_valid", 32'(o_con_valid), 32'(CON_EN));
         check("drain_byte", 32'(o_con_data), CON_EN ? 32'(b) : 32'h0);
         step(30'h10, 32'h0, 1'b0, 4'h0, 1'b1);
      end
      step(A_STAT, 32'h0, 1'b0, 4'h0, 1'b1);
      check("stat_drained", o_rdata, CON_EN ? 32'h0000_0005 : 32'h0);
      step(A_STAT, 32'h4, 1'b1, 4'h1, 1'b0);
      step(A_STAT, 32'h0, 1'b0, 4'h0, 1'b0);
      check("stat_clr", o_rdata, CON_EN ? 32'h0000_0001 : 32'h0);

      // Push and pop on a full FIFO.
      for (int b = 0; b < 4; b++) step(A_DATA, 32'h10 + 32'(b), 1'b1, 4'h1, 1'b0);
      step(A_DATA, 32'h7E, 1'b1, 4'h1, 1'b1);
      step(A_STAT, 32'h0, 1'b0, 4'h0, 1'b0);
      check("stat_pushpop", o_rdata, CON_EN ? 32'h0000_0402 : 32'h0);
      seen.delete();
      for (int b = 0; b < 4; b++) begin
         if (o_con_valid) seen.push_back(o_con_data);
         step(30'h10, 32'h0, 1'b0, 4'h0, 1'b1);
      end
      check("pushpop_count", 32'(seen.size()), CON_EN ? 32'd4 : 32'd0);
      if (seen.size() == 4) begin
         check("pushpop_first", 32'(seen[0]), 32'h11);
         check("pushpop_last", 32'(seen[3]), 32'h7E);
      end

      // Asynchronous reset mid-drain.
      step(30'h33, 32'hCAFE_F00D, 1'b1, 4'hF, 1'b0);
      for (int b = 0; b < 3; b++) step(A_DATA, 32'hA1 + 32'(b), 1'b1, 4'h1, 1'b0);
      check("pre_rst_valid", 32'(o_con_valid), 32'(CON_EN));
      i_con_ready = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("rst_valid_drop", 32'(o_con_valid), 32'h0);
      check("rst_data_zero", 32'(o_con_data), 32'h0);
      check("rst_rdata_zero", o_rdata, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      step(A_STAT, 32'h0, 1'b0, 4'h0, 1'b0);
      check("stat_after_rst", o_rdata, CON_EN ? 32'h0000_0001 : 32'h0);
      step(30'h33, 32'h0, 1'b0, 4'h0, 1'b0);
      check("ram_kept", o_rdata, 32'hCAFE_F00D);

      // Randomised traffic against the model.
      for (int i = 0; i < 16; i++) step(30'(i), $urandom, 1'b1, 4'hF, 1'b0);
      for (int i = 0; i < 400; i++) begin
         logic [29:0] a;
         a = 30'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            a[29] = 1'b0;
            a[TB_RAM_AW-1:0] = TB_RAM_AW'($urandom_range(0, 15));
         end else begin
            a[29] = 1'b1;
         end
         step(a, $urandom, 1'($urandom), 4'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Responder for the core's data-memory port: accepts the core's word address, write data, write enable and byte mask, and returns load data one cycle later. Behind the port it holds a synchronous RAM and a small MMIO page with a free-running cycle counter and a console byte FIFO. The FIFO drains to an external byte sink through a valid/ready handshake. Sits between the core's data port and the top level, opposite end of the core's load/store interface.

## Interface

- `RAM_AW`, 10, log2 of RAM depth in 32-bit words (default 4 KiB).
- `FIFO_AW`, 4, log2 of console FIFO depth in bytes; legal range 1..7.

Ports:

- `clk`  input  1  clock; all state on rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `i_addr`  input  30  word address (byte address [31:2]).
- `i_wdata`  input  32  store data, already lane-aligned.
- `i_we`  input  1  write enable.
- `i_mask`  input  4  byte enables; bit k enables `i_wdata[8k+7:8k]`.
- `o_rdata`  output  32  load data for the address sampled on the previous edge.
- `o_con_valid`  output  1  console FIFO head byte valid.
- `o_con_data`  output  8  console FIFO head byte.
- `i_con_ready`  input  1  sink accepts head byte.

## Operation

- Region decode on `i_addr[29]`:
  - 0 is RAM; index is `i_addr[RAM_AW-1:0]`, upper bits ignored (aliasing).
  - 1 is MMIO; register select is `i_addr[1:0]`, other bits ignored.
- RAM writes:
  - On an edge with `i_we`=1, only the bytes enabled in `i_mask` are written.
  - `i_mask`=0 writes nothing.
  - RAM contents are not reset.
- Reads:
  - Every cycle is a read, whatever `i_we` is.
  - `o_rdata` is registered.
  - Read-during-write to the same word returns the old word (read-first).
- MMIO registers:
  - 0 CYCLE (RO): 32-bit counter, increments every cycle, wraps 0xFFFFFFFF→0. A read returns the value held before the sampling edge. Writes are ignored.
  - 1 CON_DATA (WO): a write with `i_mask[0]`=1 pushes `i_wdata[7:0]`. Reads return 0.
  - 2 CON_STAT: read fields:
    - bit0 empty
    - bit1 full
    - bit2 overflow (sticky)
    - bits[15:8] occupancy count, zero-extended
    - other bits 0
    - A write with `i_mask[0]`=1 and `i_wdata[2]`=1 clears overflow.
  - 3: reads 0, writes ignored.
- FIFO:
  - Depth 2^FIFO_AW.
  - Push is accepted if the FIFO is not full, or if it is full and a pop happens on the same edge.
  - A push that is not accepted drops the byte and sets overflow.
  - Pop occurs when `o_con_valid` && `i_con_ready`.
  - `o_con_valid` = !empty.
  - `o_con_data` = head, held stable while valid && !ready.
- Simultaneous events:
  - Push and pop on the same edge: occupancy unchanged, both take effect.
  - Overflow clear and a rejected push on the same edge: overflow ends at 1 (set wins).
  - A STAT read in the same cycle as a push or pop returns the pre-edge state.

## Timing

- Load latency: exactly 1 cycle. Address at edge N gives `o_rdata` valid after edge N and held until edge N+1.
- Store latency: the write commits at the sampling edge and is visible to a read sampled at edge N+1.
- FIFO push at edge N gives `o_con_valid`=1 after edge N if the FIFO was empty. Push-to-output latency is 1 cycle, with no fall-through.
- Reset is asynchronous and takes effect immediately, including mid-transfer. Reset values:
  - `o_rdata`=0
  - CYCLE=0
  - FIFO empty, pointers 0, overflow=0
  - `o_con_valid`=0, `o_con_data`=0
- After reset release, the first edge samples normally. CYCLE reads 0 at the first edge and 1 at the second.
- Throughput: one access per cycle, no stalls. The block has no backpressure toward the core.

## Configuration

- `DMEM_CONSOLE_EN` defined:
  - The console FIFO and CON_DATA/CON_STAT are as described above.
- `DMEM_CONSOLE_EN` undefined:
  - No FIFO storage is built.
  - `o_con_valid`=0 and `o_con_data`=0 constantly.
  - `i_con_ready` is ignored.
  - CON_DATA writes are ignored; CON_STAT reads 0 and its writes are ignored.
  - RAM and CYCLE are unaffected.
  - The port list is identical in both builds.

## Test plan

- Byte masks:
  - Stimulus: write 0xDEADBEEF mask 0xF to addr 0x10, then 0x000000AA mask 0x1, then 0x55000000 mask 0x8, then read addr 0x10.
  - Required: read returns 0x55ADBEAA.
- Read-first:
  - Stimulus: write 0x11111111 to addr 5 while reading addr 5 in the same cycle, then read addr 5.
  - Required: first `o_rdata` is the old value, next is 0x11111111.
- Cycle counter:
  - Stimulus: release reset, then read MMIO addr 0x20000000 every cycle.
  - Required: `o_rdata` sequence is 0, 1, 2, …
  - Stimulus: force the counter near wrap.
  - Required: the read after 0xFFFFFFFF is 0.
- FIFO overflow (FIFO_AW=2, `i_con_ready`=0):
  - Stimulus: push bytes 1..5.
  - Required: STAT = 0x00000406 (count 4, full, overflow).
  - Stimulus: drain with ready=1.
  - Required: bytes 1,2,3,4 appear in order, STAT = 0x00000005.
  - Stimulus: write 0x4 to STAT.
  - Required: STAT = 0x00000001.
- Push and pop on full:
  - Stimulus: with FIFO full and ready=1, push 0x7E.
  - Required: no overflow, count stays 4, 0x7E emerges last.
- Reset mid-drain:
  - Stimulus: assert `rst` asynchronously with 3 bytes queued and valid high.
  - Required: `o_con_valid` drops immediately, STAT reads 0x00000001 after release, RAM data written before reset is still readable.
